// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a shared-memory multicycle datapath. Each instruction is
// walked through FETCH / DECODE / memory or execute / writeback states, and all
// datapath controls are driven from the current state. The unit also holds:
//   - an ALU decoder (active only in EXECUTE_R / EXECUTE_I),
//   - an NZCV flags register updated by S-bit data-processing instructions,
//   - condition-code gating of every architectural write,
//   - a sticky illegal-instruction flag, cleared only by reset.
//
// Ports:
//   clock             rising-edge system clock
//   reset_n           synchronous active-low reset
//   operation[1:0]    instruction class (00 dp, 01 mem, 10 branch, 11 undef)
//   funct[5:0]        [5] immediate, [4:1] ALU command, [0] S bit / load bit
//                     ("function" is a reserved word, hence the short name)
//   destination       destination register index
//   condition[3:0]    ARM-style condition code
//   alu_flags[3:0]    NZCV produced by the ALU this cycle
//   pc_write, address_source, instruction_write, memory_write,
//   register_write, result_source, alu_source_a, alu_source_b,
//   immediate_source, register_source, alu_control   datapath controls
//   flags[3:0]        registered NZCV
//   illegal           sticky undefined-instruction flag
//   state[3:0]        current FSM state
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int REG_ADDR_WIDTH     = 4,
    parameter int PC_REG_INDEX       = 2**REG_ADDR_WIDTH - 1,
    parameter bit ENABLE_CONDITIONAL = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [1:0]                operation,
    input  logic [5:0]                funct,
    input  logic [REG_ADDR_WIDTH-1:0] destination,
    input  logic [3:0]                condition,
    input  logic [3:0]                alu_flags,
    output logic                      pc_write,
    output logic                      address_source,
    output logic                      instruction_write,
    output logic                      memory_write,
    output logic                      register_write,
    output logic [1:0]                result_source,
    output logic                      alu_source_a,
    output logic [1:0]                alu_source_b,
    output logic [1:0]                immediate_source,
    output logic [1:0]                register_source,
    output logic [1:0]                alu_control,
    output logic [3:0]                flags,
    output logic                      illegal,
    output logic [3:0]                state
);

    localparam logic [3:0] S_FETCH         = 4'd0;
    localparam logic [3:0] S_DECODE        = 4'd1;
    localparam logic [3:0] S_MEM_ADDRESS   = 4'd2;
    localparam logic [3:0] S_MEM_READ      = 4'd3;
    localparam logic [3:0] S_MEM_WRITEBACK = 4'd4;
    localparam logic [3:0] S_MEM_WRITE     = 4'd5;
    localparam logic [3:0] S_EXECUTE_R     = 4'd6;
    localparam logic [3:0] S_EXECUTE_I     = 4'd7;
    localparam logic [3:0] S_ALU_WRITEBACK = 4'd8;
    localparam logic [3:0] S_BRANCH        = 4'd9;

    logic [3:0] state_reg, state_next;
    logic [3:0] flags_reg;
    logic       illegal_reg;
    logic       cond_hold_reg;   // condition result captured when leaving DECODE

    logic       cond_live;
    logic       cmd_valid;
    logic       cmd_arith;       // add or sub: C and V are meaningful
    logic [1:0] cmd_control;
    logic       alu_exec;
    logic       dest_is_pc;

    // ---------------------------------------------------------------------
    // Condition evaluation against the registered flags {N,Z,C,V}.
    // ---------------------------------------------------------------------
    logic flag_n, flag_z, flag_c, flag_v;
    assign flag_n = flags_reg[3];
    assign flag_z = flags_reg[2];
    assign flag_c = flags_reg[1];
    assign flag_v = flags_reg[0];

    always_comb begin
        cond_live = 1'b0;
        case (condition)
            4'b0000: cond_live = flag_z;
            4'b0001: cond_live = !flag_z;
            4'b0010: cond_live = flag_c;
            4'b0011: cond_live = !flag_c;
            4'b0100: cond_live = flag_n;
            4'b0101: cond_live = !flag_n;
            4'b0110: cond_live = flag_v;
            4'b0111: cond_live = !flag_v;
            4'b1000: cond_live = flag_c && !flag_z;
            4'b1001: cond_live = !flag_c || flag_z;
            4'b1010: cond_live = (flag_n == flag_v);
            4'b1011: cond_live = (flag_n != flag_v);
            4'b1100: cond_live = !flag_z && (flag_n == flag_v);
            4'b1101: cond_live = flag_z || (flag_n != flag_v);
            4'b1110: cond_live = 1'b1;
            default: cond_live = 1'b0;
        endcase
        if (!ENABLE_CONDITIONAL) begin
            cond_live = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // ALU command decode.
    // ---------------------------------------------------------------------
    always_comb begin
        cmd_valid   = 1'b1;
        cmd_arith   = 1'b0;
        cmd_control = 2'b00;
        case (funct[4:1])
            4'b0100: begin cmd_control = 2'b00; cmd_arith = 1'b1; end
            4'b0010: begin cmd_control = 2'b01; cmd_arith = 1'b1; end
            4'b0000: cmd_control = 2'b10;
            4'b1100: cmd_control = 2'b11;
            default: cmd_valid = 1'b0;
        endcase
    end

    assign alu_exec   = (state_reg == S_EXECUTE_R) || (state_reg == S_EXECUTE_I);
    assign dest_is_pc = (destination == REG_ADDR_WIDTH'(PC_REG_INDEX));

    // ---------------------------------------------------------------------
    // Next-state logic.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (operation)
                    2'b01:   state_next = S_MEM_ADDRESS;
                    2'b00:   state_next = funct[5] ? S_EXECUTE_I : S_EXECUTE_R;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDRESS:   state_next = funct[0] ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:      state_next = S_MEM_WRITEBACK;
            S_EXECUTE_R,
            S_EXECUTE_I:     state_next = S_ALU_WRITEBACK;
            default:         state_next = S_FETCH;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, flags and sticky illegal register.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= S_FETCH;
            flags_reg     <= 4'b0000;
            illegal_reg   <= 1'b0;
            cond_hold_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                cond_hold_reg <= cond_live;
                if (operation == 2'b11) begin
                    illegal_reg <= 1'b1;
                end
            end
            if (alu_exec) begin
                if (!cmd_valid) begin
                    illegal_reg <= 1'b1;
                end else if (cond_hold_reg && funct[0]) begin
                    flags_reg[3:2] <= alu_flags[3:2];
                    if (cmd_arith) begin
                        flags_reg[1:0] <= alu_flags[1:0];
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-state datapath controls. Conditional writes are also gated by
    // reset_n so nothing commits on an edge where reset is asserted; the
    // FETCH PC increment is left unconditional.
    // ---------------------------------------------------------------------
    always_comb begin
        pc_write          = 1'b0;
        address_source    = 1'b0;
        instruction_write = 1'b0;
        memory_write      = 1'b0;
        register_write    = 1'b0;
        result_source     = 2'b00;
        alu_source_a      = 1'b0;
        alu_source_b      = 2'b00;
        case (state_reg)
            S_FETCH: begin
                instruction_write = 1'b1;
                alu_source_a      = 1'b1;
                alu_source_b      = 2'b10;
                result_source     = 2'b10;
                pc_write          = 1'b1;
            end
            S_DECODE: begin
                alu_source_a  = 1'b1;
                alu_source_b  = 2'b10;
                result_source = 2'b10;
            end
            S_MEM_ADDRESS: alu_source_b = 2'b01;
            S_MEM_READ:    address_source = 1'b1;
            S_MEM_WRITE: begin
                address_source = 1'b1;
                memory_write   = cond_hold_reg && reset_n;
            end
            S_MEM_WRITEBACK: begin
                result_source  = 2'b01;
                register_write = cond_hold_reg && reset_n;
                pc_write       = cond_hold_reg && dest_is_pc && reset_n;
            end
            S_EXECUTE_R: alu_source_b = 2'b00;
            S_EXECUTE_I: alu_source_b = 2'b01;
            S_ALU_WRITEBACK: begin
                // An unknown ALU command writes nothing.
                register_write = cond_hold_reg && cmd_valid && reset_n;
                pc_write       = cond_hold_reg && cmd_valid && dest_is_pc && reset_n;
            end
            S_BRANCH: begin
                alu_source_b  = 2'b01;
                result_source = 2'b10;
                pc_write      = cond_hold_reg && reset_n;
            end
            default: ;
        endcase
    end

    assign alu_control      = (alu_exec && cmd_valid) ? cmd_control : 2'b00;
    assign immediate_source = operation;
    assign register_source  = {operation == 2'b01, operation == 2'b10};
    assign flags            = flags_reg;
    assign illegal          = illegal_reg;
    assign state            = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// Directed bench for multicycle_controller: walks load, store, data-processing,
// branch and undefined instructions through the FSM and checks controls and
// state against hand-computed values.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] operation;
    logic [5:0] funct;
    logic [3:0] destination;
    logic [3:0] condition;
    logic [3:0] alu_flags;
    logic       pc_write, address_source, instruction_write, memory_write;
    logic       register_write, alu_source_a, illegal;
    logic [1:0] result_source, alu_source_b, immediate_source, register_source, alu_control;
    logic [3:0] flags, state;

    int checks   = 0;
    int failures = 0;

    multicycle_controller #(
        .REG_ADDR_WIDTH(4),
        .PC_REG_INDEX(15),
        .ENABLE_CONDITIONAL(1'b1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .operation(operation),
        .funct(funct),
        .destination(destination),
        .condition(condition),
        .alu_flags(alu_flags),
        .pc_write(pc_write),
        .address_source(address_source),
        .instruction_write(instruction_write),
        .memory_write(memory_write),
        .register_write(register_write),
        .result_source(result_source),
        .alu_source_a(alu_source_a),
        .alu_source_b(alu_source_b),
        .immediate_source(immediate_source),
        .register_source(register_source),
        .alu_control(alu_control),
        .flags(flags),
        .illegal(illegal),
        .state(state)
    );

    always #5 clock = ~clock;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("check %s observed=%0h expected=%0h", tag, observed, expected);
        end
        $display("check %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] dst, input logic [3:0] cc,
                             input logic [3:0] af);
        operation   = op;
        funct       = fn;
        destination = dst;
        condition   = cc;
        alu_flags   = af;
    endtask

    initial begin
        logic [3:0] load_seq [6];
        load_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

        reset_n = 1'b0;
        set_instr(2'b00, 6'b000000, 4'd0, 4'b1110, 4'b0000);

        // Reset for two cycles then release.
        tick();
        tick();
        reset_n = 1'b1;
        check("reset_state", 8'(state), 8'd0);
        check("reset_pc_write", 8'(pc_write), 8'd1);
        check("reset_ir_write", 8'(instruction_write), 8'd1);
        check("reset_flags", 8'(flags), 8'h0);
        check("reset_illegal", 8'(illegal), 8'd0);

        // Load: 0,1,2,3,4,0 with register write only in MEM_WRITEBACK.
        set_instr(2'b01, 6'b000001, 4'd3, 4'b1110, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("load_state%0d", i), 8'(state), 8'(load_seq[i]));
            check($sformatf("load_regwr%0d", i), 8'(register_write), (load_seq[i] == 4'd4) ? 8'd1 : 8'd0);
            if (load_seq[i] == 4'd4)
                check("load_result_src", 8'(result_source), 8'b01);
            if (i < 5) tick();
        end
        check("load_register_source", 8'(register_source), 8'b10);

        // SUBS immediate, alu_flags=0110.
        set_instr(2'b00, 6'b100101, 4'd2, 4'b1110, 4'b0110);
        tick();
        check("subs_decode", 8'(state), 8'd1);
        tick();
        check("subs_exec_state", 8'(state), 8'd7);
        check("subs_alu_control", 8'(alu_control), 8'b01);
        check("subs_alu_src_b", 8'(alu_source_b), 8'b01);
        tick();
        check("subs_wb_state", 8'(state), 8'd8);
        check("subs_flags", 8'(flags), 8'b0110);
        check("subs_regwr", 8'(register_write), 8'd1);
        check("subs_pcwr", 8'(pc_write), 8'd0);
        tick();
        check("subs_done", 8'(state), 8'd0);

        // Branch EQ with Z=1: taken.
        set_instr(2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000);
        tick();
        tick();
        check("beq_taken_state", 8'(state), 8'd9);
        check("beq_taken_pcwr", 8'(pc_write), 8'd1);
        check("beq_result_src", 8'(result_source), 8'b10);
        tick();
        check("beq_taken_done", 8'(state), 8'd0);

        // ADDS register to PC, alu_flags=1000.
        set_instr(2'b00, 6'b001001, 4'd15, 4'b1110, 4'b1000);
        tick();
        tick();
        check("adds_exec_state", 8'(state), 8'd6);
        check("adds_alu_control", 8'(alu_control), 8'b00);
        check("adds_flags_before", 8'(flags), 8'b0110);
        tick();
        check("adds_pcwr", 8'(pc_write), 8'd1);
        check("adds_regwr", 8'(register_write), 8'd1);
        check("adds_flags", 8'(flags), 8'b1000);
        tick();

        // Branch EQ with Z=0: not taken.
        set_instr(2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000);
        tick();
        tick();
        check("beq_nt_state", 8'(state), 8'd9);
        check("beq_nt_pcwr", 8'(pc_write), 8'd0);
        tick();

        // ORRS with EQ failing: no register write, no flag update.
        set_instr(2'b00, 6'b011001, 4'd4, 4'b0000, 4'b0100);
        tick();
        tick();
        check("orr_alu_control", 8'(alu_control), 8'b11);
        tick();
        check("orr_regwr", 8'(register_write), 8'd0);
        tick();
        check("orr_flags", 8'(flags), 8'b1000);
        check("orr_done", 8'(state), 8'd0);

        // Undefined class: DECODE -> FETCH, sticky illegal.
        set_instr(2'b11, 6'b000000, 4'd0, 4'b1110, 4'b0000);
        check("undef_illegal_before", 8'(illegal), 8'd0);
        tick();
        check("undef_decode", 8'(state), 8'd1);
        tick();
        check("undef_back_fetch", 8'(state), 8'd0);
        check("undef_illegal", 8'(illegal), 8'd1);
        set_instr(2'b10, 6'b000000, 4'd0, 4'b1110, 4'b0000);
        tick();
        tick();
        tick();
        check("illegal_held", 8'(illegal), 8'd1);

        // Store interrupted by reset in MEM_WRITE.
        set_instr(2'b01, 6'b000000, 4'd1, 4'b1110, 4'b0000);
        tick();
        tick();
        check("store_addr_state", 8'(state), 8'd2);
        tick();
        check("store_write_state", 8'(state), 8'd5);
        check("store_memwr", 8'(memory_write), 8'd1);
        check("store_addr_src", 8'(address_source), 8'd1);
        reset_n = 1'b0;
        #1;
        check("store_reset_memwr", 8'(memory_write), 8'd0);
        tick();
        reset_n = 1'b1;
        check("store_reset_state", 8'(state), 8'd0);
        check("store_reset_illegal", 8'(illegal), 8'd0);
        check("store_reset_flags", 8'(flags), 8'h0);

        // Unknown ALU command with S bit: add, illegal, no writes.
        set_instr(2'b00, 6'b011111, 4'd5, 4'b1110, 4'b1111);
        tick();
        tick();
        check("badcmd_state", 8'(state), 8'd6);
        check("badcmd_alu_control", 8'(alu_control), 8'b00);
        tick();
        check("badcmd_regwr", 8'(register_write), 8'd0);
        check("badcmd_illegal", 8'(illegal), 8'd1);
        tick();
        check("badcmd_flags", 8'(flags), 8'h0);
        check("badcmd_done", 8'(state), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
